mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed memory slave that answers load/store requests issued by the datapath's MAR/MDR registers.
- It is the responder end of the memory interface. It latches a request, models a fixed number of wait states, performs the access, and returns a one-cycle acknowledge with read data.
- It sits between the datapath bus registers and the on-chip RAM array.

Parameters:
- ADDR_W, 9: address width in words.
- DEPTH, 512: number of implemented 32-bit words; must be no greater than 2**ADDR_W.
- WAIT_CYCLES, 2: wait states inserted before the access completes; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  32  write data; sampled with req.
- rdata  out  32  read data register.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight.
- err  out  1  out-of-range flag; only meaningful with the optional feature.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; ack=0, busy=0, err=0, rdata=32'h0; wait counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE:
    - On an edge with req=1: latch we/addr/wdata, load counter=WAIT_CYCLES, go to WAIT.
    - busy rises after that edge.
    - req=0 keeps the block in IDLE.
  - WAIT:
    - If counter!=0: decrement.
    - If counter==0: perform the access on this edge, set ack=1, go to RESP.
  - RESP: ack=0, busy=0, go to IDLE.
- Timing: req sampled at edge N means ack is high between edges N+WAIT_CYCLES+1 and N+WAIT_CYCLES+2.
  - With WAIT_CYCLES=0: ack is high in the cycle after edge N+1.
  - Next request is accepted no earlier than edge N+WAIT_CYCLES+3.
- req while busy is ignored, not queued. The requester must hold req low or re-issue it after ack.
- Read:
  - rdata <= mem[latched addr] on the ack edge; valid while ack=1.
  - rdata holds its value until the next read completes.
- Write:
  - mem[latched addr] <= latched wdata on the ack edge.
  - rdata is unchanged.
  - A read of the same address issued afterwards returns the new data.
- Inputs changing after the sampling edge have no effect; only latched values are used.
- Out-of-range (latched addr >= DEPTH): write is dropped; read returns 32'h0.
- Reset mid-operation aborts the request: no write occurs and ack is never issued.
- busy=1 in WAIT and RESP. ack and busy are both high in the ack cycle.

Optional Feature:
- Macro MEM_RESPONDER_RANGE_CHECK_EN.
- Defined: err is asserted together with ack, for the same single cycle, when the latched addr >= DEPTH. err is cleared in RESP.
- Not defined: err is tied to 0 and no comparison logic is generated. The drop/zero-read rule for out-of-range addresses still applies.

Test Plan:
- Reset: clr=0 mid-run -> ack=0, busy=0, err=0, rdata=0 immediately, without waiting for a clock edge.
- WAIT_CYCLES=2, write addr=5 data=32'hDEADBEEF at edge N, then read addr=5 -> write ack high after edge N+3; read ack returns rdata=32'hDEADBEEF.
- WAIT_CYCLES=0, back-to-back reads of addr 1 then 2 (after preloading 32'h11, 32'h22) -> acks spaced 3 cycles apart; rdata=32'h11, then 32'h22.
- req pulsed again during WAIT with addr=7 -> ignored; exactly one ack; original address accessed.
- Reset asserted during WAIT of write addr=9 data=32'h1234 -> no ack; later read of addr 9 does not return 32'h1234 (preloaded value retained).
- Macro defined, DEPTH=256, read addr=300 -> ack=1 and err=1 same cycle, rdata=0. Macro undefined -> err stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory responder: latches a load/store, inserts WAIT_CYCLES wait states, then acks for one cycle.
// Optional MEM_RESPONDER_RANGE_CHECK_EN drives err alongside ack for out-of-range addresses.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              take;
    logic              fire;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [31:0]       mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    take      = 1'b1;
                    cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    fire      = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Requests are captured once; later input changes never reach the access.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : 32'h0;

    // NOTE: the RAM array has no reset; contents survive clr and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (fire && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            rdata <= 32'h0;
        end else begin
            ack  <= fire;
            busy <= (state_nxt != S_IDLE);
            if (fire && !we_q) begin
                rdata <= rd_word;
            end
        end
    end

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    // err is only ever set on the ack edge, so it falls again when RESP is left.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err <= 1'b0;
        end else begin
            err <= fire && !in_range;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (2 wait states/256 words, 0 wait states/512 words)
// checked every cycle against a timestamp-based transaction model, plus directed literal expectations.
module tb_mem_responder;

    localparam int AW  = 9;
    localparam int WC0 = 2;
    localparam int WC1 = 0;
    localparam int D0  = 256;
    localparam int D1  = 512;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               clr;
    logic [1:0]         req_s;
    logic [1:0]         we_s;
    logic [1:0][AW-1:0] addr_s;
    logic [1:0][31:0]   wdata_s;
    logic [1:0][31:0]   rdata_s;
    logic [1:0]         ack_s;
    logic [1:0]         busy_s;
    logic [1:0]         err_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction model: a request accepted at edge N completes at edge N+W+1 and retires at N+W+2.
    bit          m_pend  [2];
    int          m_done  [2];
    bit          m_we    [2];
    int          m_addr  [2];
    logic [31:0] m_wd    [2];
    bit          e_ack   [2];
    bit          e_busy  [2];
    bit          e_err   [2];
    logic [31:0] e_rd    [2];
    bit          e_rd_ok [2];
    logic [31:0] m_mem   [2][512];
    bit          m_known [2][512];

    mem_responder #(.ADDR_W(AW), .DEPTH(D0), .WAIT_CYCLES(WC0)) u_slow (
        .clk   (clk),
        .clr   (clr),
        .req   (req_s[0]),
        .we    (we_s[0]),
        .addr  (addr_s[0]),
        .wdata (wdata_s[0]),
        .rdata (rdata_s[0]),
        .ack   (ack_s[0]),
        .busy  (busy_s[0]),
        .err   (err_s[0])
    );

    mem_responder #(.ADDR_W(AW), .DEPTH(D1), .WAIT_CYCLES(WC1)) u_fast (
        .clk   (clk),
        .clr   (clr),
        .req   (req_s[1]),
        .we    (we_s[1]),
        .addr  (addr_s[1]),
        .wdata (wdata_s[1]),
        .rdata (rdata_s[1]),
        .ack   (ack_s[1]),
        .busy  (busy_s[1]),
        .err   (err_s[1])
    );

    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? WC0 : WC1;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d] at cycle %0d: got %h, expected %h", name, inst, cyc, got, exp);
        end
    endtask

    task automatic timeout(input string name, input int inst);
        checks++;
        errors++;
        $display("FAIL %s [dut%0d] at cycle %0d: no response within cycle budget", name, inst, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = 1'b0;
            e_ack[i]   = 1'b0;
            e_busy[i]  = 1'b0;
            e_err[i]   = 1'b0;
            e_rd[i]    = 32'h0;
            e_rd_ok[i] = 1'b1;
        end
    endtask

    always @(negedge clr) model_reset();

    always @(posedge clk) begin
        cyc++;
        if (clr === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i] && cyc == m_done[i]) begin
                    e_ack[i] = 1'b1;
                    e_err[i] = RC && (m_addr[i] >= dep(i));
                    if (m_we[i]) begin
                        if (m_addr[i] < dep(i)) begin
                            m_mem[i][m_addr[i]]   = m_wd[i];
                            m_known[i][m_addr[i]] = 1'b1;
                        end
                    end else if (m_addr[i] < dep(i)) begin
                        e_rd[i]    = m_mem[i][m_addr[i]];
                        e_rd_ok[i] = m_known[i][m_addr[i]];
                    end else begin
                        e_rd[i]    = 32'h0;
                        e_rd_ok[i] = 1'b1;
                    end
                end else if (m_pend[i] && cyc == m_done[i] + 1) begin
                    e_ack[i]  = 1'b0;
                    e_err[i]  = 1'b0;
                    e_busy[i] = 1'b0;
                    m_pend[i] = 1'b0;
                end else if (!m_pend[i] && req_s[i]) begin
                    m_pend[i] = 1'b1;
                    m_we[i]   = we_s[i];
                    m_addr[i] = int'(addr_s[i]);
                    m_wd[i]   = wdata_s[i];
                    m_done[i] = cyc + wc(i) + 1;
                    e_busy[i] = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (clr === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                check("ack", i, 32'(ack_s[i]), 32'(e_ack[i]));
                check("busy", i, 32'(busy_s[i]), 32'(e_busy[i]));
                check("err", i, 32'(err_s[i]), 32'(e_err[i]));
                if (e_rd_ok[i]) check("rdata", i, rdata_s[i], e_rd[i]);
            end
        end
    end

    task automatic wait_idle(input int i);
        for (int k = 0; k < 50; k++) begin
            if (!m_pend[i]) return;
            @(negedge clk);
        end
        timeout("idle_wait", i);
    endtask

    task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [31:0] d, output int n);
        wait_idle(i);
        @(negedge clk);
        req_s[i]   = 1'b1;
        we_s[i]    = w;
        addr_s[i]  = a;
        wdata_s[i] = d;
        @(posedge clk);
        #1;
        n          = cyc;
        req_s[i]   = 1'b0;
        we_s[i]    = 1'($urandom);
        addr_s[i]  = AW'($urandom);
        wdata_s[i] = $urandom;
    endtask

    task automatic wait_ack(input int i, input bit junk, output int e);
        e = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_s[i]) begin
                e = cyc;
                if (junk) req_s[i] = 1'b0;
                return;
            end
            if (junk) begin
                req_s[i]   = 1'($urandom);
                we_s[i]    = 1'($urandom);
                addr_s[i]  = AW'($urandom);
                wdata_s[i] = $urandom;
            end
        end
        timeout("ack_wait", i);
    endtask

    task automatic txn(input int i, input bit w, input logic [AW-1:0] a, input logic [31:0] d, output int n, output int e);
        issue(i, w, a, d, n);
        wait_ack(i, 1'b1, e);
    endtask

    task automatic count_acks(input int i, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ack_s[i]) cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, e, e1, e2, cnt;
        logic [AW-1:0] a;

        model_reset();
        clr     = 1'b0;
        req_s   = '0;
        we_s    = '0;
        addr_s  = '0;
        wdata_s = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", i, 32'(ack_s[i]), 32'h0);
            check("rst_busy", i, 32'(busy_s[i]), 32'h0);
            check("rst_err", i, 32'(err_s[i]), 32'h0);
            check("rst_rdata", i, rdata_s[i], 32'h0);
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Two wait states: write then read back, ack three edges after sampling.
        txn(0, 1'b1, 9'd5, 32'hDEADBEEF, n, e);
        check("wr_latency", 0, 32'(e - n), 32'd3);
        txn(0, 1'b0, 9'd5, 32'h0, n, e);
        check("rd_latency", 0, 32'(e - n), 32'd3);
        check("rd_data", 0, rdata_s[0], 32'hDEADBEEF);
        check("rd_busy_with_ack", 0, 32'(busy_s[0]), 32'h1);

        // Zero wait states: req held high across two reads, acks three cycles apart.
        txn(1, 1'b1, 9'd1, 32'h11, n, e);
        txn(1, 1'b1, 9'd2, 32'h22, n, e);
        wait_idle(1);
        @(negedge clk);
        req_s[1]  = 1'b1;
        we_s[1]   = 1'b0;
        addr_s[1] = 9'd1;
        @(posedge clk);
        #1;
        n         = cyc;
        addr_s[1] = 9'd2;
        wait_ack(1, 1'b0, e1);
        check("b2b_first_latency", 1, 32'(e1 - n), 32'd1);
        check("b2b_first_data", 1, rdata_s[1], 32'h11);
        repeat (2) @(posedge clk);
        #1;
        req_s[1] = 1'b0;
        wait_ack(1, 1'b0, e2);
        check("b2b_spacing", 1, 32'(e2 - e1), 32'd3);
        check("b2b_second_data", 1, rdata_s[1], 32'h22);

        // A second req pulse during WAIT is ignored; only the first request is serviced.
        txn(0, 1'b1, 9'd7, 32'h77, n, e);
        issue(0, 1'b1, 9'd12, 32'hAAAA, n);
        @(negedge clk);
        req_s[0]   = 1'b1;
        we_s[0]    = 1'b1;
        addr_s[0]  = 9'd7;
        wdata_s[0] = 32'hBBBB;
        @(negedge clk);
        req_s[0] = 1'b0;
        wait_ack(0, 1'b0, e);
        check("ignored_req_latency", 0, 32'(e - n), 32'd3);
        count_acks(0, 8, cnt);
        check("ignored_req_extra_acks", 0, 32'(cnt), 32'd0);
        txn(0, 1'b0, 9'd7, 32'h0, n, e);
        check("ignored_req_addr7", 0, rdata_s[0], 32'h77);
        txn(0, 1'b0, 9'd12, 32'h0, n, e);
        check("ignored_req_addr12", 0, rdata_s[0], 32'hAAAA);

        // Reset during WAIT aborts the write and clears outputs without a clock edge.
        txn(0, 1'b1, 9'd9, 32'hCAFE0009, n, e);
        issue(0, 1'b1, 9'd9, 32'h1234, n);
        #2;
        clr = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_ack", i, 32'(ack_s[i]), 32'h0);
            check("async_rst_busy", i, 32'(busy_s[i]), 32'h0);
            check("async_rst_err", i, 32'(err_s[i]), 32'h0);
            check("async_rst_rdata", i, rdata_s[i], 32'h0);
        end
        count_acks(0, 3, cnt);
        clr = 1'b1;
        begin
            int more;
            count_acks(0, 6, more);
            check("aborted_no_ack", 0, 32'(cnt + more), 32'd0);
        end
        txn(0, 1'b0, 9'd9, 32'h0, n, e);
        check("aborted_write_dropped", 0, rdata_s[0], 32'hCAFE0009);

        // Range boundary on the 256-word instance.
        txn(0, 1'b1, 9'd255, 32'h0000_00FF, n, e);
        check("edge_wr_err", 0, 32'(err_s[0]), 32'h0);
        txn(0, 1'b1, 9'd44, 32'h0000_0044, n, e);
        txn(0, 1'b1, 9'd300, 32'h0BAD_0BAD, n, e);
        check("oor_wr_err", 0, 32'(err_s[0]), RC ? 32'h1 : 32'h0);
        txn(0, 1'b0, 9'd300, 32'h0, n, e);
        check("oor_rd_latency", 0, 32'(e - n), 32'd3);
        check("oor_rd_data", 0, rdata_s[0], 32'h0);
        check("oor_rd_err", 0, 32'(err_s[0]), RC ? 32'h1 : 32'h0);
        txn(0, 1'b0, 9'd44, 32'h0, n, e);
        check("oor_no_alias", 0, rdata_s[0], 32'h0000_0044);
        txn(0, 1'b0, 9'd255, 32'h0, n, e);
        check("edge_rd_data", 0, rdata_s[0], 32'h0000_00FF);
        txn(0, 1'b0, 9'd256, 32'h0, n, e);
        check("first_oor_rd_data", 0, rdata_s[0], 32'h0);

        // Randomised traffic; every cycle is checked by the compare process.
        for (int t = 0; t < 200; t++) begin
            int  i;
            bit  w;
            i = int'($urandom_range(1, 0));
            w = 1'($urandom);
            if ($urandom_range(3, 0) == 0) a = AW'($urandom_range(511, 240));
            else a = AW'($urandom_range(15, 0));
            txn(i, w, a, $urandom, n, e);
            if (e >= 0) check("rand_latency", i, 32'(e - n), 32'(wc(i) + 1));
        end

        wait_idle(0);
        wait_idle(1);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
